// File: rtl/mtr_pkg.sv
// Shared widths, side-sequencer state codes and command saturation helper for the
// motor command sequencer.
package mtr_pkg;

  localparam int unsigned SPD_W = 11;
  localparam int unsigned CMD_W = 12;
  localparam logic [SPD_W-1:0] SPD_MAX = 11'h7FF;

  typedef logic [1:0] side_st_t;

  localparam side_st_t StRun   = 2'd0;
  localparam side_st_t StDecel = 2'd1;
  localparam side_st_t StDead  = 2'd2;

  // |cmd| clipped to SPD_MAX; only -2048 overflows the magnitude range.
  function automatic logic [SPD_W-1:0] cmd_mag(input logic [CMD_W-1:0] cmd);
    logic [CMD_W-1:0] abs_v;
    abs_v = cmd[CMD_W-1] ? (~cmd + 12'd1) : cmd;
    return abs_v[CMD_W-1] ? SPD_MAX : abs_v[SPD_W-1:0];
  endfunction

endpackage

// File: rtl/mtr_side_seq.sv
// One motor side: command latch, slew-limited ramp and zero-speed dead time around
// every direction reversal.
module mtr_side_seq
  import mtr_pkg::*;
#(
  parameter int unsigned STEP     = 16,
  parameter int unsigned DEAD_CYC = 512
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             cmd_vld_i,
  input  logic [CMD_W-1:0] cmd_i,
  output logic [SPD_W-1:0] spd_o,
  output logic             rev_o,
  output logic             busy_o
);

  localparam int unsigned DW = $clog2(DEAD_CYC + 1);
  localparam logic [CMD_W-1:0] StepW = CMD_W'(STEP);
  localparam logic [SPD_W-1:0] StepS = SPD_W'(STEP);
  localparam logic [DW-1:0] DeadLd = DW'(DEAD_CYC);

  side_st_t         st_q, st_d;
  logic [SPD_W-1:0] spd_q, spd_d;
  logic             rev_q, rev_d;
  logic [SPD_W-1:0] mag_q, mag_d;
  logic             dir_q, dir_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;

  logic [SPD_W-1:0] eff;
  logic             mismatch;
  logic [CMD_W-1:0] up_sum;
  logic [SPD_W-1:0] ramp_up, ramp_dn, approach, decel;

  always_comb begin
    eff      = en_i ? mag_q : '0;
    mismatch = (dir_q != rev_q);
    // 12-bit sums keep spd+STEP and tgt+STEP free of wrap-around
    up_sum   = {1'b0, spd_q} + StepW;
    ramp_up  = (up_sum > {1'b0, eff}) ? eff : up_sum[SPD_W-1:0];
    ramp_dn  = ({1'b0, spd_q} >= ({1'b0, eff} + StepW)) ? (spd_q - StepS) : eff;
    approach = (eff > spd_q) ? ramp_up : ramp_dn;
    decel    = (spd_q > StepS) ? (spd_q - StepS) : '0;
  end

  always_comb begin
    st_d   = st_q;
    spd_d  = spd_q;
    rev_d  = rev_q;
    dcnt_d = dcnt_q;
    case (st_q)
      StRun: begin
        if (mismatch && (eff != '0) && (spd_q == '0)) begin
          st_d   = StDead;
          dcnt_d = DeadLd;
        end else if (tick_i) begin
          if (mismatch && (eff != '0)) begin
            spd_d = decel;
            if (decel == '0) begin
              st_d   = StDead;
              dcnt_d = DeadLd;
            end else begin
              st_d = StDecel;
            end
          end else begin
            spd_d = approach;
          end
        end
      end
      StDecel: begin
        if (!mismatch) begin
          st_d = StRun;
        end else if (spd_q == '0) begin
          st_d   = StDead;
          dcnt_d = DeadLd;
        end else if (tick_i) begin
          spd_d = decel;
          if (decel == '0) begin
            st_d   = StDead;
            dcnt_d = DeadLd;
          end
        end
      end
      StDead: begin
        spd_d = '0;
        if (dcnt_q == DW'(1)) begin
          rev_d = dir_q;
          st_d  = StRun;
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      default: st_d = StRun;
    endcase
  end

  // A zero command keeps the old direction so it can never start a reversal.
  always_comb begin
    mag_d = cmd_vld_i ? cmd_mag(cmd_i) : mag_q;
    dir_d = (cmd_vld_i && (cmd_i != '0)) ? cmd_i[CMD_W-1] : dir_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= StRun;
      spd_q  <= '0;
      rev_q  <= 1'b0;
      mag_q  <= '0;
      dir_q  <= 1'b0;
      dcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      spd_q  <= spd_d;
      rev_q  <= rev_d;
      mag_q  <= mag_d;
      dir_q  <= dir_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign spd_o  = spd_q;
  assign rev_o  = rev_q;
  assign busy_o = (spd_q != eff) || mismatch || (st_q == StDead);

endmodule

// File: rtl/mtr_cmd_seq.sv
// Motor command sequencer: shared ramp tick plus one slew/dead-time sequencer per side.
module mtr_cmd_seq
  import mtr_pkg::*;
#(
  parameter int unsigned RAMP_DIV = 2048,
  parameter int unsigned STEP     = 16,
  parameter int unsigned DEAD_CYC = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmd_vld,
  input  logic [CMD_W-1:0] lft_cmd,
  input  logic [CMD_W-1:0] rght_cmd,
  output logic [SPD_W-1:0] lft_spd,
  output logic             lft_rev,
  output logic [SPD_W-1:0] rght_spd,
  output logic             rght_rev,
  output logic             busy
);

  localparam int unsigned TW = $clog2(RAMP_DIV);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tick;
  logic          lft_busy, rght_busy;

  // Free-running divider; commands never restart it.
  always_comb begin
    tick   = (tcnt_q == TW'(RAMP_DIV - 1));
    tcnt_d = tick ? '0 : (tcnt_q + TW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  mtr_side_seq #(
    .STEP     (STEP),
    .DEAD_CYC (DEAD_CYC)
  ) u_lft (
    .clk_i     (clk),
    .rst_i     (rst),
    .tick_i    (tick),
    .en_i      (en),
    .cmd_vld_i (cmd_vld),
    .cmd_i     (lft_cmd),
    .spd_o     (lft_spd),
    .rev_o     (lft_rev),
    .busy_o    (lft_busy)
  );

  mtr_side_seq #(
    .STEP     (STEP),
    .DEAD_CYC (DEAD_CYC)
  ) u_rght (
    .clk_i     (clk),
    .rst_i     (rst),
    .tick_i    (tick),
    .en_i      (en),
    .cmd_vld_i (cmd_vld),
    .cmd_i     (rght_cmd),
    .spd_o     (rght_spd),
    .rev_o     (rght_rev),
    .busy_o    (rght_busy)
  );

  assign busy = lft_busy | rght_busy;

endmodule

// File: tb/tb_mtr_cmd_seq.sv
// Self-checking bench for mtr_cmd_seq: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_mtr_cmd_seq;

  localparam int RAMP_DIV = 4;
  localparam int STEP     = 64;
  localparam int DEAD_CYC = 8;

  localparam int Running = 0;
  localparam int Braking = 1;
  localparam int Holding = 2;

  logic        clk = 1'b0;
  logic        rst, en, cmd_vld;
  logic [11:0] lft_cmd, rght_cmd;
  logic [10:0] lft_spd, rght_spd;
  logic        lft_rev, rght_rev, busy;

  mtr_cmd_seq #(
    .RAMP_DIV (RAMP_DIV),
    .STEP     (STEP),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cmd_vld  (cmd_vld),
    .lft_cmd  (lft_cmd),
    .rght_cmd (rght_cmd),
    .lft_spd  (lft_spd),
    .lft_rev  (lft_rev),
    .rght_spd (rght_spd),
    .rght_rev (rght_rev),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  bit chk_en;

  // Model state per side (0 = left, 1 = right).
  int m_spd[2];
  bit m_rev[2];
  int m_mode[2];
  int m_hold[2];
  int m_mag[2];
  bit m_dir[2];
  int m_tc;

  task automatic start_hold(input int s);
    m_mode[s] = Holding;
    m_hold[s] = DEAD_CYC;
  endtask

  task automatic brake(input int s);
    m_spd[s] = (m_spd[s] > STEP) ? m_spd[s] - STEP : 0;
    if (m_spd[s] == 0) start_hold(s);
    else m_mode[s] = Braking;
  endtask

  task automatic model_step();
    bit tk;
    int eff;
    int cmdv[2];
    int mag;
    cmdv[0] = $signed(lft_cmd);
    cmdv[1] = $signed(rght_cmd);
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        m_spd[s] = 0; m_rev[s] = 0; m_mode[s] = Running;
        m_hold[s] = 0; m_mag[s] = 0; m_dir[s] = 0;
      end
      m_tc = 0;
      return;
    end
    tk = (m_tc == RAMP_DIV - 1);
    for (int s = 0; s < 2; s++) begin
      eff = en ? m_mag[s] : 0;
      case (m_mode[s])
        Running: begin
          if (m_dir[s] != m_rev[s] && eff != 0 && m_spd[s] == 0) start_hold(s);
          else if (tk) begin
            if (m_dir[s] != m_rev[s] && eff != 0) brake(s);
            else if (eff > m_spd[s]) m_spd[s] = (m_spd[s] + STEP < eff) ? m_spd[s] + STEP : eff;
            else m_spd[s] = (m_spd[s] - STEP > eff) ? m_spd[s] - STEP : eff;
          end
        end
        Braking: begin
          if (m_dir[s] == m_rev[s]) m_mode[s] = Running;
          else if (m_spd[s] == 0) start_hold(s);
          else if (tk) brake(s);
        end
        default: begin
          if (m_hold[s] == 1) begin
            m_rev[s]  = m_dir[s];
            m_mode[s] = Running;
          end else begin
            m_hold[s]--;
          end
        end
      endcase
      if (cmd_vld) begin
        if (cmdv[s] != 0) m_dir[s] = (cmdv[s] < 0);
        mag = (cmdv[s] < 0) ? -cmdv[s] : cmdv[s];
        m_mag[s] = (mag > 2047) ? 2047 : mag;
      end
    end
    m_tc = tk ? 0 : m_tc + 1;
  endtask

  function automatic bit model_busy();
    int eff;
    for (int s = 0; s < 2; s++) begin
      eff = en ? m_mag[s] : 0;
      if (m_spd[s] != eff || m_rev[s] != m_dir[s] || m_mode[s] == Holding) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: model advances with the DUT, inputs then change 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    logic [24:0] got, want;
    if (chk_en) begin
      got  = {lft_spd, lft_rev, rght_spd, rght_rev, busy};
      want = {11'(m_spd[0]), m_rev[0], 11'(m_spd[1]), m_rev[1], model_busy()};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL model t=%0t got lspd=%0d lrev=%0b rspd=%0d rrev=%0b busy=%0b, want lspd=%0d lrev=%0b rspd=%0d rrev=%0b busy=%0b",
                 $time, lft_spd, lft_rev, rght_spd, rght_rev, busy,
                 m_spd[0], m_rev[0], m_spd[1], m_rev[1], model_busy());
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  task automatic next_spd(input int s, output int v);
    int old, n;
    old = s ? int'(rght_spd) : int'(lft_spd);
    n = 0;
    while ((s ? int'(rght_spd) : int'(lft_spd)) == old && n < 100) begin
      cyc();
      n++;
    end
    v = s ? int'(rght_spd) : int'(lft_spd);
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout side %0d spd stuck at %0d, want a change within 100 clocks", s, old);
    end
  endtask

  task automatic send(input int l, input int r);
    lft_cmd  = 12'(l);
    rght_cmd = 12'(r);
    cmd_vld  = 1'b1;
    cyc();
    cmd_vld  = 1'b0;
  endtask

  initial begin
    int v, n, ticks, prev, r;
    vectors = 0; miscompares = 0; chk_en = 0;
    rst = 1'b1; en = 1'b1; cmd_vld = 1'b0; lft_cmd = '0; rght_cmd = '0;
    cyc(); cyc();
    chk_en = 1;
    check("rst_lspd", lft_spd, 0);
    check("rst_rspd", rght_spd, 0);
    check("rst_revs", {lft_rev, rght_rev}, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (20) cyc();
    check("idle_outs", {lft_spd, lft_rev, rght_spd, rght_rev, busy}, 0);

    send(256, 0);
    for (int i = 0; i < 4; i++) begin
      next_spd(0, v);
      check("ramp_up", v, 64 * (i + 1));
      check("ramp_rspd", rght_spd, 0);
    end
    check("ramp_rev", lft_rev, 0);
    check("ramp_busy", busy, 0);

    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_spd(0, v);
      check("en_off_down", v, 192 - 64 * i);
      check("en_off_rev", lft_rev, 0);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_spd(0, v);
      check("en_on_up", v, 64 * (i + 1));
    end

    send(-128, 0);
    for (int i = 0; i < 4; i++) begin
      next_spd(0, v);
      check("rev_decel", v, 192 - 64 * i);
    end
    n = 1;
    while (!lft_rev && n < 50) begin
      cyc();
      if (!lft_rev) n++;
    end
    check("rev_dead_len", n, DEAD_CYC);
    check("rev_flip", lft_rev, 1);
    check("rev_flip_spd", lft_spd, 0);
    next_spd(0, v);
    check("rev_up1", v, 64);
    next_spd(0, v);
    check("rev_up2", v, 128);
    check("rev_busy", busy, 0);

    send(-128, -2048);
    n = 0;
    while (!rght_rev && n < 50) begin
      cyc();
      if (!rght_rev) n++;
    end
    check("r_dead_len", n, DEAD_CYC);
    check("r_flip", rght_rev, 1);
    check("r_flip_spd", rght_spd, 0);
    ticks = 0; prev = 0; v = 0;
    while (v != 2047 && ticks < 40) begin
      prev = v;
      next_spd(1, v);
      ticks++;
    end
    check("r_ticks", ticks, 32);
    check("r_last_from", prev, 1984);

    send(128, -2048);
    next_spd(0, v);
    check("rst_dec1", v, 64);
    next_spd(0, v);
    check("rst_dec0", v, 0);
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    check("rst_dead_outs", {lft_spd, lft_rev, rght_spd, rght_rev, busy}, 0);
    rst = 1'b0;
    send(64, 0);
    n = 0;
    while (lft_spd == 0 && n < 20) begin
      cyc();
      n++;
    end
    check("post_rst_spd", lft_spd, 64);
    check("post_rst_first_tick", (n <= RAMP_DIV) ? 1 : 0, 1);
    check("post_rst_rev", lft_rev, 0);

    for (int k = 0; k < 3000; k++) begin
      cmd_vld = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 9);
      lft_cmd = (r == 0) ? 12'h000 : (r == 1) ? 12'h800 : 12'($urandom_range(0, 4095));
      r = $urandom_range(0, 9);
      rght_cmd = (r == 0) ? 12'h000 : (r == 1) ? 12'h800 : 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 99) == 0) en = ~en;
      rst = ($urandom_range(0, 799) == 0);
      cyc();
    end
    cmd_vld = 1'b0;
    rst = 1'b0;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
